branch_issue_ctrl: RTL
======================

# branch_issue_ctrl

Sequencing controller for the ID-stage branch compare unit of the five-stage MIPS pipeline. It keeps a shadow of in-flight register writes in E/M/W and decides each cycle whether the branch in ID may resolve now or must stall. When it may resolve, it selects the forwarding source for each compare operand, issues the compare opcode, and turns the compare result into the PC redirect. It also keeps saturating branch and stall statistics for the performance CSR path.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistic counters.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_is_branch` in 1: the ID instruction is a conditional branch.
- `id_cmp_op` in 4: compare opcode. Beq=0000, Bne=0001, Rs-forms 0010–0111, Rt-forms 1000–1101.
- `id_rs`, `id_rt` in 5 each: source register numbers.
- `id_wr_en` in 1, `id_wr_addr` in 5: the ID instruction writes a GPR.
- `id_tnew` in 2: cycles after entering E until the result sits in a forwardable register. ALU=1, load=2. A value of 0 is treated as 1.
- `ext_stall` in 1: stall request from the general hazard unit.
- `to_branch` in 1: compare-unit result.
- `stall` out 1: ID/IF freeze request from this block.
- `fwd_sel_a`, `fwd_sel_b` out 2 each: operand source. 00 = regfile, 01 = EX/MEM, 10 = MEM/WB.
- `cmp_op_out` out 4: opcode driven to the compare unit.
- `branch_go` out 1: branch resolves this cycle.
- `pc_redirect` out 1: take the branch target.
- `stat_branches`, `stat_stall_cycles` out `CNT_W` each.

## Operation
- Operand use is decoded from `id_cmp_op`:
  - 0000/0001 use rs and rt.
  - 0010–0111 use rs only.
  - 1000–1101 use rt only.
  - 1110/1111 use neither; the compare yields 0, so the branch is never taken.
- Shadow entries E, M, W each hold {valid, addr, tnew}.
- Per used operand with a nonzero register number, scan the entries youngest-first: E, then M, then W. The first valid entry with a matching addr decides the result:
  - Match in E: hazard, because E is never a forward source.
  - Match in M or W with tnew>0: hazard.
  - Match in M or W with tnew=0: the select is 01 (M) or 10 (W).
  - No match: the select is 00.
- A register number of $0 never matches; its select is 00.
- `stall` = `id_valid` & `id_is_branch` & (hazard on either used operand).
- `branch_go` = `id_valid` & `id_is_branch` & ~`stall` & ~`ext_stall`.
- `pc_redirect` = `branch_go` & `to_branch`.
- `cmp_op_out` = `id_cmp_op` passes through unconditionally.
- When the block does not resolve a branch, `fwd_sel_*` = 00.
- Shadow advance on every clock:
  - W <= M with tnew-1, saturating at 0.
  - M <= E with tnew-1, saturating at 0.
  - E <= the ID write info when ID advances (~`stall` & ~`ext_stall` & `id_valid` & `id_wr_en` & addr≠0); otherwise E <= a bubble (valid=0).
- Counters:
  - `stat_branches` increments when `branch_go` = 1.
  - `stat_stall_cycles` increments when `stall` = 1.
  - Both saturate at all-ones.

## Timing
- `stall`, `fwd_sel_*`, `branch_go` and `pc_redirect` are combinational from the ID inputs and the shadow registers, with zero latency.
- The shadow and the counters update on the rising edge of `clk`.
- Reset clears all shadow valid bits and both counters on the next edge. After reset every output is 0; `cmp_op_out` follows its input.
- Reset asserted mid-stall: the shadow clears, so a branch still held in ID sees no hazard and `stall` drops in the cycle after reset.
- The hazard follows an instruction through the pipeline:
  - ALU producer immediately before the branch: 1 stall cycle, then forward from M.
  - Load producer immediately before the branch: 2 stall cycles, then forward from W.
  - Load producer two instructions before the branch: 1 stall cycle, then forward from W.
- `ext_stall` and a hazard together: `stall` = 1 and E receives a bubble. `stat_stall_cycles` counts only this block's own stall.
- Simultaneous matches for the same register in M and W: the M entry decides.

## Structure
- Shared package/header holds:
  - the compare-opcode constants (common with the compare unit),
  - the forward-select constants FWD_RF=00, FWD_M=01, FWD_W=10.
- Sub-module `branch_operand_check`, instanced once for rs and once for rt:
  - inputs: register number, use flag, the three shadow entries;
  - outputs: hazard, fwd_sel.
- The top level holds the shadow registers, the advance logic and the counters.

## Test plan
- ALU write to $8, then `beq $8,$9` with op 0000 in the next cycle:
  - `stall` = 1 for 1 cycle;
  - then `fwd_sel_a` = 01, `fwd_sel_b` = 00, `branch_go` = 1;
  - `stat_stall_cycles` = 1.
- lw to $8, then op 0010 (rs-bgez) with rs=8:
  - `stall` = 1 for 2 cycles;
  - then `fwd_sel_a` = 10;
  - `to_branch` = 1 gives `pc_redirect` = 1.
- Op 1011 (rt-bltz) with rt=0 while E holds a write to $0:
  - no stall, `fwd_sel_b` = 00.
- $10 written by a load now in W (tnew 0) and by an ALU op now in M (tnew 0), then op 0001 with rs=10:
  - `fwd_sel_a` = 01.
- `ext_stall` = 1 for 3 cycles with a branch that has no hazard in ID:
  - `branch_go` = 0 throughout and E holds bubbles;
  - on release, `branch_go` = 1 and `stat_branches` increments by exactly 1.
- `reset` pulse during the second stall cycle of a load-use branch:
  - next cycle `stall` = 0, shadow empty, counters = 0.

Source files
------------

// File: rtl/branch_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_ctrl_pkg
// Purpose  : Shared compare-opcode encodings, forward-select codes, shadow
//            entry type and small decode helpers for the ID-stage branch
//            issue controller and the compare unit.
// Revision : 1.0 - initial release
// ============================================================================
package branch_issue_ctrl_pkg;

  // Compare opcodes (common with the compare unit).
  localparam logic [3:0] OP_BEQ      = 4'b0000;
  localparam logic [3:0] OP_BNE      = 4'b0001;
  localparam logic [3:0] OP_BGEZ_RS  = 4'b0010;
  localparam logic [3:0] OP_BGTZ_RS  = 4'b0011;
  localparam logic [3:0] OP_BLEZ_RS  = 4'b0100;
  localparam logic [3:0] OP_BLTZ_RS  = 4'b0101;
  localparam logic [3:0] OP_BEQZ_RS  = 4'b0110;
  localparam logic [3:0] OP_BNEZ_RS  = 4'b0111;
  localparam logic [3:0] OP_BGEZ_RT  = 4'b1000;
  localparam logic [3:0] OP_BGTZ_RT  = 4'b1001;
  localparam logic [3:0] OP_BLEZ_RT  = 4'b1010;
  localparam logic [3:0] OP_BLTZ_RT  = 4'b1011;
  localparam logic [3:0] OP_BEQZ_RT  = 4'b1100;
  localparam logic [3:0] OP_BNEZ_RT  = 4'b1101;
  localparam logic [3:0] OP_NEVER_0  = 4'b1110;
  localparam logic [3:0] OP_NEVER_1  = 4'b1111;

  // Operand forward-select codes.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b01;
  localparam logic [1:0] FWD_W  = 2'b10;

  // One in-flight register write tracked in E, M or W.
  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic [1:0] tnew;
  } shadow_t;

  // Two-register compares and rs-only forms read rs.
  function automatic logic op_uses_rs(input logic [3:0] op);
    return (op <= OP_BNEZ_RS);
  endfunction

  // Two-register compares and rt-only forms read rt.
  function automatic logic op_uses_rt(input logic [3:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) ||
           ((op >= OP_BGEZ_RT) && (op <= OP_BNEZ_RT));
  endfunction

  // One pipeline step closer to being forwardable, floored at zero.
  function automatic logic [1:0] tnew_age(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_operand_check.sv
`default_nettype none
// ============================================================================
// Module   : branch_operand_check
// Purpose  : Scans the E/M/W write shadow youngest-first for one compare
//            operand and reports either a hazard or the forward source.
// Revision : 1.0 - initial release
// ============================================================================
module branch_operand_check
  import branch_issue_ctrl_pkg::*;
(
  input  logic [4:0] reg_num,
  input  logic       use_op,
  input  shadow_t    ent_e,
  input  shadow_t    ent_m,
  input  shadow_t    ent_w,
  output logic       hazard,
  output logic [1:0] fwd_sel
);

  logic w_hit_e;
  logic w_hit_m;
  logic w_hit_w;

  // $0 is hardwired, so it never matches an in-flight write.
  assign w_hit_e = ent_e.valid && (ent_e.addr == reg_num);
  assign w_hit_m = ent_m.valid && (ent_m.addr == reg_num);
  assign w_hit_w = ent_w.valid && (ent_w.addr == reg_num);

  // Youngest matching producer decides; E is never a forward source.
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = FWD_RF;
    if (use_op && (reg_num != 5'd0)) begin
      if (w_hit_e) begin
        hazard = 1'b1;
      end else if (w_hit_m) begin
        if (ent_m.tnew != 2'd0) hazard  = 1'b1;
        else                    fwd_sel = FWD_M;
      end else if (w_hit_w) begin
        if (ent_w.tnew != 2'd0) hazard  = 1'b1;
        else                    fwd_sel = FWD_W;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_issue_ctrl
// Purpose  : ID-stage branch sequencing: tracks in-flight writes in E/M/W,
//            stalls or forwards compare operands, issues the compare and
//            produces the PC redirect, plus saturating branch/stall stats.
// Revision : 1.0 - initial release
// ============================================================================
module branch_issue_ctrl
  import branch_issue_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_is_branch,
  input  logic [3:0]       id_cmp_op,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_addr,
  input  logic [1:0]       id_tnew,
  input  logic             ext_stall,
  input  logic             to_branch,
  output logic             stall,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [3:0]       cmp_op_out,
  output logic             branch_go,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_stall_cycles
);

  shadow_t          r_e;
  shadow_t          r_m;
  shadow_t          r_w;
  logic [CNT_W-1:0] r_branches;
  logic [CNT_W-1:0] r_stall_cycles;

  logic             w_use_rs;
  logic             w_use_rt;
  logic             w_hazard_a;
  logic             w_hazard_b;
  logic [1:0]       w_sel_a;
  logic [1:0]       w_sel_b;
  logic             w_is_branch;
  logic             w_id_advance;
  shadow_t          w_e_next;

  assign w_use_rs = op_uses_rs(id_cmp_op);
  assign w_use_rt = op_uses_rt(id_cmp_op);

  branch_operand_check u_check_rs (
    .reg_num (id_rs),
    .use_op  (w_use_rs),
    .ent_e   (r_e),
    .ent_m   (r_m),
    .ent_w   (r_w),
    .hazard  (w_hazard_a),
    .fwd_sel (w_sel_a)
  );

  branch_operand_check u_check_rt (
    .reg_num (id_rt),
    .use_op  (w_use_rt),
    .ent_e   (r_e),
    .ent_m   (r_m),
    .ent_w   (r_w),
    .hazard  (w_hazard_b),
    .fwd_sel (w_sel_b)
  );

  assign w_is_branch = id_valid && id_is_branch;
  assign stall       = w_is_branch && (w_hazard_a || w_hazard_b);
  assign branch_go   = w_is_branch && !stall && !ext_stall;
  assign pc_redirect = branch_go && to_branch;
  assign cmp_op_out  = id_cmp_op;

  // Forward selects are only meaningful while a branch actually resolves.
  assign fwd_sel_a = branch_go ? w_sel_a : FWD_RF;
  assign fwd_sel_b = branch_go ? w_sel_b : FWD_RF;

  // ID instruction enters E only when it really moves on and writes a GPR.
  assign w_id_advance = !stall && !ext_stall && id_valid && id_wr_en &&
                        (id_wr_addr != 5'd0);

  // Next E entry: the advancing writer, or a bubble; tnew of 0 means 1.
  always_comb begin
    w_e_next = '0;
    if (w_id_advance) begin
      w_e_next.valid = 1'b1;
      w_e_next.addr  = id_wr_addr;
      w_e_next.tnew  = (id_tnew == 2'd0) ? 2'd1 : id_tnew;
    end
  end

  // Shadow advances every cycle, ageing tnew as entries move down.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_e      <= w_e_next;
      r_m      <= r_e;
      r_m.tnew <= tnew_age(r_e.tnew);
      r_w      <= r_m;
      r_w.tnew <= tnew_age(r_m.tnew);
    end
  end

  // Saturating statistics; the stall count covers only this block's stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branches     <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (branch_go && (r_branches != {CNT_W{1'b1}}))
        r_branches <= r_branches + 1'b1;
      if (stall && (r_stall_cycles != {CNT_W{1'b1}}))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stat_branches     = r_branches;
  assign stat_stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
